// File: rtl/ttl299_shift_register_pkg.sv
// Shared encodings for the 74xx-style register blocks: manual mode select and
// the auto-shift sequencer states.
package ttl299_shift_register_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/ttl_tristate_buffer.sv
// Octal-style 3-state output stage: drives data when oe_n_i is low, floats otherwise.
module ttl_tristate_buffer #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             oe_n_i,
    output logic [WIDTH-1:0] data_o
);

    assign data_o = oe_n_i ? {WIDTH{1'bz}} : data_i;

endmodule

// File: rtl/ttl299_shift_register.sv
// Universal shift/storage register (hold, shift right/left, load) with 3-state
// outputs, always-driven cascade taps and an N-place auto-shift sequencer.
module ttl299_shift_register
    import ttl299_shift_register_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     D,
    input  logic [1:0]           S,
    input  logic                 DSR,
    input  logic                 DSL,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] count,
    input  logic                 dir,
    input  logic                 OE1_n,
    input  logic                 OE2_n,
    output logic [WIDTH-1:0]     Q,
    output logic                 Q0,
    output logic                 Qn,
    output logic                 busy,
    output logic                 done
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     internal_register;
    logic [WIDTH-1:0]     reg_d;
    logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                 dir_q, dir_d;
    logic [WIDTH-1:0]     shr_value;
    logic [WIDTH-1:0]     shl_value;

    assign shr_value = {DSR, internal_register[WIDTH-1:1]};
    assign shl_value = {internal_register[WIDTH-2:0], DSL};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            internal_register <= '0;
            remaining_q       <= '0;
            dir_q             <= 1'b0;
        end else begin
            state_q           <= state_d;
            internal_register <= reg_d;
            remaining_q       <= remaining_d;
            dir_q             <= dir_d;
        end
    end

    // Next-state logic; DONE behaves as IDLE for accepting new work.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (count == CNT_ZERO) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (remaining_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: sequencer shifts take priority, then start, then manual mode.
    always_comb begin
        reg_d       = internal_register;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        if (state_q == ST_SHIFT) begin
            reg_d       = dir_q ? shl_value : shr_value;
            remaining_d = remaining_q - CNT_ONE;
        end else if (start) begin
            remaining_d = count;
            dir_d       = dir;
        end else begin
            case (mode_e'(S))
                MODE_HOLD: reg_d = internal_register;
                MODE_SHR:  reg_d = shr_value;
                MODE_SHL:  reg_d = shl_value;
                MODE_LOAD: reg_d = D;
                default:   reg_d = internal_register;
            endcase
        end
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign Q0 = internal_register[0];
    assign Qn = internal_register[WIDTH-1];

    ttl_tristate_buffer #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .data_i (internal_register),
        .oe_n_i (OE1_n | OE2_n),
        .data_o (Q)
    );

endmodule
